// File: rtl/uart_fifo_core.sv
// uart_fifo_core - parametrised UART transceiver with a buffered receiver.
//
// Clocked by the baud generator's oversample clock (sampleclk); every bit
// lasts OSR sampleclk cycles.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : adds a parity bit after the data bits (PARITY_ODD selects odd
//               parity); received words with bad parity are dropped and
//               flagged on parity_err.
//   undefined : frame is start + DATA_W data + STOP_BITS stop; parity_err = 0.
//
// Ports
//   sampleclk    oversample clock
//   reset        asynchronous, active-low reset
//   uart_rx      serial input pin (asynchronous to sampleclk)
//   uart_tx      serial output pin (idles high)
//   tx_data      word to transmit, latched when tx_en is accepted
//   tx_en        transmit request, accepted only while tx_ready=1
//   tx_ready     transmitter idle
//   rx_data      RX FIFO head word, valid while rx_valid=1
//   rx_valid     RX FIFO not empty
//   rx_rd        pop the RX FIFO head
//   rx_count     RX FIFO occupancy
//   err_clr      clear the sticky error flags
//   rx_overrun   sticky: received word dropped because the FIFO was full
//   frame_err    sticky: stop bit sampled low
//   parity_err   sticky: parity mismatch
module uart_fifo_core #(
  parameter int DATA_W    = 8,
  parameter int OSR       = 16,
  parameter int RX_DEPTH  = 4,
  parameter int STOP_BITS = 1
`ifdef UART_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                            sampleclk,
  input  logic                            reset,
  input  logic                            uart_rx,
  output logic                            uart_tx,
  input  logic [DATA_W-1:0]               tx_data,
  input  logic                            tx_en,
  output logic                            tx_ready,
  output logic [DATA_W-1:0]               rx_data,
  output logic                            rx_valid,
  input  logic                            rx_rd,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
  input  logic                            err_clr,
  output logic                            rx_overrun,
  output logic                            frame_err,
  output logic                            parity_err
);

  // Cycle counter is wide enough for the longest phase (two stop bits).
  localparam int CW = $clog2(2 * OSR);
  localparam int BW = $clog2(DATA_W);
  localparam int PW = $clog2(RX_DEPTH);
  localparam int NW = $clog2(RX_DEPTH + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(OSR - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * OSR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(RX_DEPTH);

`ifdef UART_PARITY_EN
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    parity_of = (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t         tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] tx_shift;
`ifdef UART_PARITY_EN
  logic              tx_par;
`endif

  // Transmit FSM; uart_tx and tx_ready are registered so the pin never glitches.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
      uart_tx  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_en) begin
            tx_shift <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= parity_of(tx_data);
`endif
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_START;
            uart_tx  <= 1'b0;
            tx_ready <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
              uart_tx  <= tx_par;
`else
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
`endif
            end else begin
              // The shifter holds the current bit in [0]; present the next one.
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_STOP;
            uart_tx  <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == STOP_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_tx  <= 1'b1;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

  logic rx_s1, rx_s2, rx_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // Reset to the idle-high level so reset release never looks like a start bit.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t         rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              push;
  logic              frame_set;
`ifdef UART_PARITY_EN
  logic              par_bad;
  logic              parity_set;
`endif

  // Receive FSM. Sampling is phased from the detected falling edge so every
  // later sample lands mid-bit; it returns to IDLE at the stop-bit sample.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      push       <= 1'b0;
      frame_set  <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      parity_set <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_set <= 1'b0;
`ifdef UART_PARITY_EN
      parity_set <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_BIT) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // A high line at mid start bit is a glitch, not a frame.
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            par_bad  <= (rx_s2 != parity_of(rx_shift));
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // Framing error outranks a parity error on the same frame.
            if (!rx_s2) begin
              frame_set <= 1'b1;
`ifdef UART_PARITY_EN
            end else if (par_bad) begin
              parity_set <= 1'b1;
`endif
            end else begin
              push <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

  // RX FIFO. The pushed word is rx_shift itself: it stays stable for many
  // cycles after the stop-bit sample, until the next frame's first data bit.
  logic [DATA_W-1:0] mem [RX_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [NW-1:0]     cnt_next;
  logic              do_pop, do_push, full;

  // Push/pop qualification; a pop frees a slot for a push in the same cycle.
  always_comb begin
    do_pop   = rx_rd && rx_valid;
    full     = (rx_count == FULL_CNT);
    do_push  = push && (!full || do_pop);
    cnt_next = rx_count;
    if (do_push && !do_pop) begin
      cnt_next = rx_count + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_next = rx_count - 1'b1;
    end else begin
      cnt_next = rx_count;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge sampleclk) begin
    if (do_push) begin
      mem[wptr] <= rx_shift;
    end
  end

  // FIFO pointers (wrap naturally, depth is a power of two) and occupancy.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      rx_count <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      rx_count <= cnt_next;
      rx_valid <= (cnt_next != '0);
    end
  end

  assign rx_data = mem[rptr];

  // Sticky error flags; a new error in the clearing cycle keeps its flag set.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_overrun <= (push && full && !do_pop) || (rx_overrun && !err_clr);
      frame_err  <= frame_set || (frame_err && !err_clr);
`ifdef UART_PARITY_EN
      parity_err <= parity_set || (parity_err && !err_clr);
`else
      parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
`timescale 1ns/1ps
module tb_uart_fifo_core;

  logic       sampleclk = 1'b0;
  logic       reset     = 1'b0;
  logic       uart_rx;
  logic       uart_tx;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_en     = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd     = 1'b0;
  logic [2:0] rx_count;
  logic       err_clr   = 1'b0;
  logic       rx_overrun, frame_err, parity_err;

  logic loop   = 1'b0;
  logic rx_drv = 1'b1;
  assign uart_rx = loop ? uart_tx : rx_drv;

  always #5 sampleclk = ~sampleclk;

  uart_fifo_core dut (
    .sampleclk (sampleclk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_rd     (rx_rd),
    .rx_count  (rx_count),
    .err_clr   (err_clr),
    .rx_overrun(rx_overrun),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  localparam int S_COUNT = 0, S_VALID = 1, S_OVR = 2, S_FRM = 3, S_PAR = 4, S_TX = 5, S_RDY = 6;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } chk_t;

  chk_t       chkq[$];
  logic [1:0] txq[$];    // expected {uart_tx, tx_ready}, one entry per cycle
  logic [7:0] rxq[$];    // expected words in pop order

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-derived line sequence for 0xA5: start, 1,0,1,0,0,1,0,1, stop.
  int a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [7:0] words [8];

  function automatic int probe(input int sel);
    case (sel)
      S_COUNT: probe = int'(rx_count);
      S_VALID: probe = int'(rx_valid);
      S_OVR:   probe = int'(rx_overrun);
      S_FRM:   probe = int'(frame_err);
      S_PAR:   probe = int'(parity_err);
      S_TX:    probe = int'(uart_tx);
      S_RDY:   probe = int'(tx_ready);
      default: probe = -1;
    endcase
  endfunction

  // Monitor: on every falling edge, consume pending expectations.
  always @(negedge sampleclk) begin
    chk_t       c;
    int         act;
    logic [1:0] w;
    logic [7:0] e;
    while (chkq.size() > 0) begin
      c   = chkq.pop_front();
      act = probe(c.sel);
      n_cmp++;
      if (act != c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", c.name, act, c.exp, $time);
      end
    end
    if (txq.size() > 0) begin
      w = txq.pop_front();
      n_cmp++;
      if ({uart_tx, tx_ready} !== w) begin
        n_bad++;
        $display("FAIL tx_wave: got tx=%b ready=%b, expected tx=%b ready=%b (t=%0t)",
                 uart_tx, tx_ready, w[1], w[0], $time);
      end
    end
    if (rx_rd && rx_valid) begin
      n_cmp++;
      if (rxq.size() == 0) begin
        n_bad++;
        $display("FAIL rx_pop: unexpected word %h", rx_data);
      end else begin
        e = rxq.pop_front();
        if (rx_data !== e) begin
          n_bad++;
          $display("FAIL rx_pop: got %h, expected %h", rx_data, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sampleclk);
      #1;
    end
  endtask

  task automatic expect_val(input string name, input int sel, input int exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chkq.push_back(c);
  endtask

  task automatic wait_ready(input logic lvl, input string name);
    int k;
    k = 0;
    while (tx_ready !== lvl && k < 400) begin
      tick();
      k++;
    end
    if (tx_ready !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, tx_ready=%b, expected %b", name, tx_ready, lvl);
    end
  endtask

  // Send words[0..n-1] back to back by keeping tx_en high between frames.
  task automatic tx_frames(input int n);
    for (int i = 0; i < n; i++) begin
      tx_data = words[i];
      tx_en   = 1'b1;
      tick();
      wait_ready(1'b0, "tx_accept");
      if (i == n - 1) tx_en = 1'b0;
      wait_ready(1'b1, "tx_done");
    end
  endtask

  // Expected line and ready for cycles 1..161 after accepting 0xA5.
  task automatic push_a5_wave();
    for (int b = 0; b < 10; b++) begin
      repeat (16) txq.push_back({a5_seq[b][0], 1'b0});
    end
    txq.push_back(2'b11);
  endtask

  task automatic send_a5_checked();
    tx_data = 8'hA5;
    tx_en   = 1'b1;
    tick();              // acceptance edge; now in cycle 1
    tx_en   = 1'b0;
    push_a5_wave();
    tick(170);
  endtask

  task automatic rx_frame(input logic [7:0] w, input logic stop);
    rx_drv = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = w[i];
      tick(16);
    end
    rx_drv = stop;
    tick(16);
    rx_drv = 1'b1;
    tick(20);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    tick(3);
    expect_val("rst_tx", S_TX, 1);
    expect_val("rst_ready", S_RDY, 1);
    expect_val("rst_valid", S_VALID, 0);
    expect_val("rst_count", S_COUNT, 0);
    expect_val("rst_ovr", S_OVR, 0);
    expect_val("rst_frm", S_FRM, 0);
    expect_val("rst_par", S_PAR, 0);
    tick();
    reset = 1'b1;
    tick(3);

    // Exact TX waveform for 0xA5.
    send_a5_checked();

    // Loopback, two back-to-back words.
    loop = 1'b1;
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    rxq.push_back(8'h3C);
    rxq.push_back(8'hC3);
    tx_frames(2);
    tick(30);
    expect_val("loop_count", S_COUNT, 2);
    expect_val("loop_valid", S_VALID, 1);
    expect_val("loop_frm", S_FRM, 0);
    expect_val("loop_ovr", S_OVR, 0);
    tick();
    pop();
    pop();
    expect_val("loop_empty", S_COUNT, 0);
    tick();

    // Overrun: five words into a four-deep FIFO.
    for (int i = 0; i < 5; i++) words[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) rxq.push_back(8'(i + 1));
    tx_frames(5);
    tick(30);
    expect_val("ovr_count", S_COUNT, 4);
    expect_val("ovr_flag", S_OVR, 1);
    expect_val("ovr_valid", S_VALID, 1);
    tick();
    pulse_clr();
    expect_val("ovr_cleared", S_OVR, 0);
    expect_val("ovr_count_kept", S_COUNT, 4);
    tick();
    repeat (4) pop();
    expect_val("ovr_drained_count", S_COUNT, 0);
    expect_val("ovr_drained_valid", S_VALID, 0);
    tick();
    loop = 1'b0;

    // Framing error, then a good frame.
    rx_frame(8'h55, 1'b0);
    expect_val("frm_flag", S_FRM, 1);
    expect_val("frm_count", S_COUNT, 0);
    tick();
    rxq.push_back(8'h12);
    rx_frame(8'h12, 1'b1);
    expect_val("good_count", S_COUNT, 1);
    expect_val("frm_sticky", S_FRM, 1);
    tick();
    pop();
    pulse_clr();
    expect_val("frm_cleared", S_FRM, 0);
    tick();

    // Short low glitch must be rejected.
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(30);
    expect_val("glitch_count", S_COUNT, 0);
    expect_val("glitch_valid", S_VALID, 0);
    expect_val("glitch_frm", S_FRM, 0);
    expect_val("glitch_ovr", S_OVR, 0);
    tick();

    // Reset during data bit 3 (cycles 65..80 after acceptance).
    tx_data = 8'h00;
    tx_en   = 1'b1;
    tick();
    tx_en   = 1'b0;
    tick(70);
    expect_val("midtx_line", S_TX, 0);
    expect_val("midtx_busy", S_RDY, 0);
    tick();
    reset = 1'b0;
    expect_val("midrst_tx", S_TX, 1);
    expect_val("midrst_ready", S_RDY, 1);
    tick(2);
    reset = 1'b1;
    tick(2);
    send_a5_checked();

    tick(5);
    n_cmp++;
    if (rxq.size() != 0) begin
      n_bad++;
      $display("FAIL rx_leftover: got %0d words not received, expected 0", rxq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
